// File: rtl/fix_pkg.sv
// Shared constants and parser state type for the FIX receive framer.
package fix_pkg;

  localparam logic [7:0] SOH        = 8'h01;
  localparam logic [7:0] ASCII_8    = 8'h38;
  localparam logic [7:0] ASCII_1    = 8'h31;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_DIG0 = 8'h30;

  typedef enum logic [2:0] {
    IDLE,
    BODY,
    T1,
    T0,
    CK
  } parse_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_byte_fifo.sv
// Store-and-forward byte FIFO: speculative writes become readable only on commit,
// and rewind discards everything written since the last commit.
module fix_byte_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       commit,
  input  logic       rewind,
  input  logic       rd_en,
  output logic [8:0] rd_data,
  output logic       full,
  output logic       empty,
  output logic       committed_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] wr_ptr_adv;
  logic          wr_ok;
  logic [8:0]    mem [DEPTH];

  // One slot is kept unused so full and empty are distinguishable with plain pointers.
  assign full            = (wr_ptr + PW'(1)) == rd_ptr;
  assign empty           = wr_ptr == rd_ptr;
  assign committed_empty = rd_ptr == commit_ptr;
  assign rd_data         = mem[rd_ptr];

  assign wr_ok      = wr_en & ~full;
  assign wr_ptr_adv = wr_ok ? wr_ptr + PW'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      wr_ptr <= rewind ? commit_ptr : wr_ptr_adv;
      if (commit) begin
        commit_ptr <= wr_ptr_adv;
      end
      if (rd_en && !committed_empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fix_rx_framer.sv
// FIX receive framer: finds message boundaries in the TOE byte stream, verifies
// tag 10, and forwards only complete checksum-valid messages to fix_engine.
module fix_rx_framer
  import fix_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       toe_data_i,
  input  logic             toe_valid_i,
  output logic             toe_ready_o,
  output logic [7:0]       msg_o,
  output logic             msg_valid_o,
  input  logic             msg_ready_i,
  output logic             new_message_o,
  output logic             msg_last_o,
  output logic             checksum_err_o,
  output logic             frame_err_o,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] bad_cnt_o
);

  parse_state_e state, state_nxt;
  logic [7:0]   sum, sum_nxt;
  logic [7:0]   fsum, fsum_nxt;
  logic [9:0]   val, val_nxt;
  logic [1:0]   ndig, ndig_nxt;
  logic         fstart, fstart_nxt;
  logic         wr_en, commit, rewind, ck_bad, fr_bad;
  logic         fifo_full, fifo_empty, fifo_cempty;
  logic [8:0]   rd_data;
  logic         at_start;
  logic         accept;
  logic [7:0]   dig;

  assign toe_ready_o = rst & ((state == IDLE) | ~fifo_full);
  assign accept      = toe_valid_i & toe_ready_o;
  assign dig         = toe_data_i - ASCII_DIG0;

  always_comb begin
    state_nxt  = state;
    sum_nxt    = sum;
    fsum_nxt   = fsum;
    val_nxt    = val;
    ndig_nxt   = ndig;
    fstart_nxt = fstart;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rewind     = 1'b0;
    ck_bad     = 1'b0;
    fr_bad     = 1'b0;
    // Full with nothing committed ahead: the message can never fit, so drop it.
    if ((state != IDLE) && fifo_full && fifo_cempty) begin
      rewind    = 1'b1;
      fr_bad    = 1'b1;
      state_nxt = IDLE;
    end else if (accept) begin
      fstart_nxt = (toe_data_i == SOH);
      unique case (state)
        IDLE: begin
          if (toe_data_i == ASCII_8) begin
            wr_en     = 1'b1;
            sum_nxt   = ASCII_8;
            state_nxt = BODY;
          end
        end
        BODY: begin
          wr_en   = 1'b1;
          sum_nxt = sum + toe_data_i;
          if (fstart && (toe_data_i == ASCII_1)) begin
            fsum_nxt  = sum;
            state_nxt = T1;
          end
        end
        T1: begin
          wr_en     = 1'b1;
          sum_nxt   = sum + toe_data_i;
          state_nxt = (toe_data_i == ASCII_0) ? T0 : BODY;
        end
        T0: begin
          wr_en   = 1'b1;
          sum_nxt = sum + toe_data_i;
          if (toe_data_i == ASCII_EQ) begin
            val_nxt   = '0;
            ndig_nxt  = '0;
            state_nxt = CK;
          end else begin
            state_nxt = BODY;
          end
        end
        CK: begin
          if (is_digit(toe_data_i) && (ndig < 2'd3)) begin
            wr_en    = 1'b1;
            val_nxt  = val * 10'd10 + {2'b00, dig};
            ndig_nxt = ndig + 2'd1;
          end else if ((toe_data_i == SOH) && (ndig == 2'd3)) begin
            wr_en     = 1'b1;
            state_nxt = IDLE;
            if (val == {2'b00, fsum}) begin
              commit = 1'b1;
            end else begin
              rewind = 1'b1;
              ck_bad = 1'b1;
            end
          end else begin
            rewind    = 1'b1;
            fr_bad    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  fix_byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        ({commit, toe_data_i}),
    .commit         (commit),
    .rewind         (rewind & ~fifo_empty),
    .rd_en          (msg_ready_i),
    .rd_data        (rd_data),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .committed_empty(fifo_cempty)
  );

  assign msg_valid_o   = ~fifo_cempty;
  assign msg_o         = rd_data[7:0];
  assign msg_last_o    = msg_valid_o & rd_data[8];
  assign new_message_o = msg_valid_o & at_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sum            <= '0;
      fsum           <= '0;
      val            <= '0;
      ndig           <= '0;
      fstart         <= 1'b0;
      at_start       <= 1'b1;
      checksum_err_o <= 1'b0;
      frame_err_o    <= 1'b0;
      good_cnt_o     <= '0;
      bad_cnt_o      <= '0;
    end else begin
      state          <= state_nxt;
      sum            <= sum_nxt;
      fsum           <= fsum_nxt;
      val            <= val_nxt;
      ndig           <= ndig_nxt;
      fstart         <= fstart_nxt;
      checksum_err_o <= ck_bad;
      frame_err_o    <= fr_bad;
      if (msg_valid_o && msg_ready_i) begin
        at_start <= rd_data[8];
      end
      if (commit) begin
        good_cnt_o <= good_cnt_o + CNT_W'(1);
      end
      if (ck_bad || fr_bad) begin
        bad_cnt_o <= bad_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fix_rx_framer.sv
// Bench for fix_rx_framer: DEPTH=16 instance (index 0) and DEPTH=64 instance (index 1).
module tb_fix_rx_framer;

  localparam int K_GOOD = 0;
  localparam int K_CK   = 1;
  localparam int K_FR   = 2;

  typedef struct {
    int    d;
    bit    rdy;
    string s;
    int    kind;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  toe_data    [2];
  logic        toe_valid   [2];
  logic        toe_ready   [2];
  logic [7:0]  msg         [2];
  logic        msg_valid   [2];
  logic        msg_ready   [2];
  logic        new_message [2];
  logic        msg_last    [2];
  logic        ck_err      [2];
  logic        fr_err      [2];
  logic [15:0] good_cnt    [2];
  logic [15:0] bad_cnt     [2];

  logic [9:0] eq0[$], eq1[$], oq0[$], oq1[$];
  int ck_cnt[2] = '{0, 0};
  int fr_cnt[2] = '{0, 0};
  int mgood[2], mbad[2], mck[2], mfr[2];
  int n_vec  = 0;
  int n_fail = 0;
  vec_t vt[8];

  always #5 clk = ~clk;

  fix_rx_framer #(.DEPTH(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .toe_data_i(toe_data[0]), .toe_valid_i(toe_valid[0]), .toe_ready_o(toe_ready[0]),
    .msg_o(msg[0]), .msg_valid_o(msg_valid[0]), .msg_ready_i(msg_ready[0]),
    .new_message_o(new_message[0]), .msg_last_o(msg_last[0]),
    .checksum_err_o(ck_err[0]), .frame_err_o(fr_err[0]),
    .good_cnt_o(good_cnt[0]), .bad_cnt_o(bad_cnt[0])
  );

  fix_rx_framer #(.DEPTH(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst(rst),
    .toe_data_i(toe_data[1]), .toe_valid_i(toe_valid[1]), .toe_ready_o(toe_ready[1]),
    .msg_o(msg[1]), .msg_valid_o(msg_valid[1]), .msg_ready_i(msg_ready[1]),
    .new_message_o(new_message[1]), .msg_last_o(msg_last[1]),
    .checksum_err_o(ck_err[1]), .frame_err_o(fr_err[1]),
    .good_cnt_o(good_cnt[1]), .bad_cnt_o(bad_cnt[1])
  );

  // Observed output bytes and error pulses, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (msg_valid[d] === 1'b1 && msg_ready[d] === 1'b1) begin
        if (d == 0) oq0.push_back({new_message[d], msg_last[d], msg[d]});
        else        oq1.push_back({new_message[d], msg_last[d], msg[d]});
      end
      if (ck_err[d] === 1'b1) ck_cnt[d]++;
      if (fr_err[d] === 1'b1) fr_cnt[d]++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] chr(input string s, input int i);
    logic [7:0] c;
    c = s[i];
    return (c == 8'h7C) ? 8'h01 : c;
  endfunction

  function automatic int eq_size(input int d);
    return (d == 0) ? eq0.size() : eq1.size();
  endfunction

  function automatic int oq_size(input int d);
    return (d == 0) ? oq0.size() : oq1.size();
  endfunction

  task automatic push_exp(input int d, input string s);
    int st;
    logic [9:0] e;
    st = -1;
    for (int i = 0; i < s.len(); i++) begin
      if (st < 0 && chr(s, i) == 8'h38) st = i;
    end
    for (int i = (st < 0) ? s.len() : st; i < s.len(); i++) begin
      e = {(i == st), (i == s.len() - 1), chr(s, i)};
      if (d == 0) eq0.push_back(e);
      else        eq1.push_back(e);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the byte.
  task automatic send_byte(input int d, input logic [7:0] b);
    int n;
    bit ok;
    toe_data[d]  = b;
    toe_valid[d] = 1'b1;
    ok = 1'b0;
    for (n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (toe_ready[d] === 1'b1) ok = 1'b1;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    toe_valid[d] = 1'b0;
  endtask

  task automatic send_str(input int d, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(d, chr(s, i));
  endtask

  task automatic drain_check(input int d);
    int n;
    logic [9:0] e, o;
    n = 0;
    while (n < 300 && oq_size(d) < eq_size(d)) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    if (n >= 300) check("drain_timeout", oq_size(d), eq_size(d));
    while (eq_size(d) > 0) begin
      if (d == 0) e = eq0.pop_front();
      else        e = eq1.pop_front();
      if (oq_size(d) == 0) begin
        check("byte_missing", 32'hFFFF, {22'd0, e});
      end else begin
        if (d == 0) o = oq0.pop_front();
        else        o = oq1.pop_front();
        check("out_byte{new,last,data}", {22'd0, o}, {22'd0, e});
      end
    end
    while (oq_size(d) > 0) begin
      if (d == 0) o = oq0.pop_front();
      else        o = oq1.pop_front();
      check("unexpected_byte", {22'd0, o}, 32'hFFFF);
    end
  endtask

  task automatic check_state(input int d);
    check("good_cnt", good_cnt[d], mgood[d]);
    check("bad_cnt", bad_cnt[d], mbad[d]);
    check("checksum_err_pulses", ck_cnt[d], mck[d]);
    check("frame_err_pulses", fr_cnt[d], mfr[d]);
    check("msg_valid_idle", msg_valid[d], 32'd0);
  endtask

  initial begin
    string m1, m2;
    m1 = "8=A|10=183|";
    m2 = "8=B|10=184|";
    vt[0] = '{1, 1'b1, "8=A|10=183|",          K_GOOD};
    vt[1] = '{1, 1'b1, "8=A|10=184|",          K_CK};
    vt[2] = '{1, 1'b1, "UU8=A|12=B|10=154|",   K_GOOD};
    vt[3] = '{1, 1'b1, "8=A|10=18|",           K_FR};
    vt[4] = '{1, 1'b1, "8=A|10=1834|",         K_FR};
    vt[5] = '{0, 1'b0, "8=AAAAAAAAAAAAAAAAA|", K_FR};
    vt[6] = '{0, 1'b1, "8=A|10=183|",          K_GOOD};
    vt[7] = '{1, 1'b1, "8=B|10=184|",          K_GOOD};

    for (int d = 0; d < 2; d++) begin
      toe_data[d] = '0; toe_valid[d] = 1'b0; msg_ready[d] = 1'b1;
      mgood[d] = 0; mbad[d] = 0; mck[d] = 0; mfr[d] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_toe_ready", toe_ready[d], 32'd0);
      check("reset_msg_valid", msg_valid[d], 32'd0);
      check("reset_good_cnt", good_cnt[d], 32'd0);
      check("reset_bad_cnt", bad_cnt[d], 32'd0);
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check("post_reset_toe_ready", toe_ready[d], 32'd1);
    @(posedge clk);
    #1;

    foreach (vt[k]) begin
      msg_ready[vt[k].d] = vt[k].rdy;
      if (vt[k].kind == K_GOOD) begin
        push_exp(vt[k].d, vt[k].s);
        mgood[vt[k].d]++;
      end else begin
        mbad[vt[k].d]++;
        if (vt[k].kind == K_CK) mck[vt[k].d]++;
        else                    mfr[vt[k].d]++;
      end
      send_str(vt[k].d, vt[k].s);
      drain_check(vt[k].d);
      check_state(vt[k].d);
    end

    // Backpressure: second message stalls on a full DEPTH=16 FIFO.
    msg_ready[0] = 1'b0;
    push_exp(0, m1);
    push_exp(0, m2);
    send_str(0, m1);
    for (int i = 0; i < 4; i++) send_byte(0, chr(m2, i));
    toe_data[0]  = chr(m2, 4);
    toe_valid[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("toe_ready_while_full", toe_ready[0], 32'd0);
    end
    check("committed_msg_visible", msg_valid[0], 32'd1);
    @(posedge clk);
    #1;
    msg_ready[0] = 1'b1;
    for (int i = 4; i < m2.len(); i++) send_byte(0, chr(m2, i));
    mgood[0] += 2;
    drain_check(0);
    check_state(0);

    // Reset in the middle of a message.
    for (int i = 0; i < 7; i++) send_byte(1, chr(m1, i));
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midreset_good_cnt", good_cnt[d], 32'd0);
      check("midreset_bad_cnt", bad_cnt[d], 32'd0);
      check("midreset_toe_ready", toe_ready[d], 32'd0);
      check("midreset_msg_valid", msg_valid[d], 32'd0);
      mgood[d] = 0;
      mbad[d]  = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("after_midreset_toe_ready", toe_ready[1], 32'd1);
    @(posedge clk);
    #1;
    push_exp(1, m1);
    mgood[1]++;
    send_str(1, m1);
    drain_check(1);
    check_state(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
